ptp_rx_parser: RTL

PTP_RX_PARSER -- requirements
Module: ptp_rx_parser

---
 rtl/ptp_rx_parser.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ptp_rx_parser.sv
// PTPv2 receive parser: extracts timestamp fields from a UDP payload byte stream,
// buffers accepted records in a small FIFO and exposes them over a Wishbone slave.
module ptp_rx_parser #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LEN    = 44
) (
  input  logic        c10_clk50m,
  input  logic        clean_rst_long_n,
  input  logic [7:0]  axis_tdata_i,
  input  logic        axis_tvalid_i,
  input  logic        axis_tlast_i,
  input  logic        axis_tuser_i,
  output logic        axis_tready_o,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_data_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        irq_o
);

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L   = 5'(FIFO_DEPTH);
  localparam logic [6:0] MIN_LEN_L = 7'(MIN_LEN);

  // IDLE: waiting for first byte | RECV: mid-frame | COMMIT: push record or count drop
  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;
  state_t state_q, state_d;

  logic          beat, commit, frame_ok, push, pop, drop, empty, full;
  logic          wb_fire, pop_req, cnt_clr;
  logic [5:0]    idx_q;
  logic [6:0]    len_q;
  logic          err_q;
  logic [3:0]    msg_q, ver_q;
  logic [15:0]   seq_q;
  logic [47:0]   sec_q;
  logic [31:0]   ns_q;
  logic [99:0]   mem [FIFO_DEPTH];
  logic [99:0]   head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q;
  logic [31:0]   rx_cnt_q, drop_cnt_q, rd_data;
  logic          unused_ok;

  assign unused_ok = ^{wbs_addr_i[31:5], wbs_addr_i[1:0], wbs_data_i};

  assign beat = axis_tvalid_i & axis_tready_o;

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:   if (beat) state_d = axis_tlast_i ? COMMIT : RECV;
      RECV:   if (beat && axis_tlast_i) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = beat ? (axis_tlast_i ? COMMIT : RECV) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte index, frame length and sticky error; a byte arriving during COMMIT starts the next frame.
  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      axis_tready_o <= 1'b0;
      idx_q         <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
      msg_q         <= '0;
      ver_q         <= '0;
      seq_q         <= '0;
      sec_q         <= '0;
      ns_q          <= '0;
    end else begin
      axis_tready_o <= 1'b1;
      if (beat) begin
        if (axis_tlast_i) begin
          idx_q <= '0;
          len_q <= {1'b0, idx_q} + 7'd1;
        end else if (idx_q != 6'd63) begin
          idx_q <= idx_q + 6'd1;
        end
        if (idx_q == 6'd0) msg_q <= axis_tdata_i[3:0];
        if (idx_q == 6'd1) ver_q <= axis_tdata_i[3:0];
        if (idx_q == 6'd30 || idx_q == 6'd31) seq_q <= {seq_q[7:0], axis_tdata_i};
        if (idx_q >= 6'd34 && idx_q <= 6'd39) sec_q <= {sec_q[39:0], axis_tdata_i};
        if (idx_q >= 6'd40 && idx_q <= 6'd43) ns_q <= {ns_q[23:0], axis_tdata_i};
      end
      if (commit)                      err_q <= beat & axis_tuser_i;
      else if (beat && axis_tuser_i)   err_q <= 1'b1;
    end
  end

  assign wb_fire  = wbs_stb_i & ~wbs_ack_o;
  assign pop_req  = wb_fire & wbs_we_i & (wbs_addr_i[4:2] == 3'd5);
  assign cnt_clr  = wb_fire & wbs_we_i & (wbs_addr_i[4:2] == 3'd6);

  assign empty    = (level_q == 5'd0);
  assign full     = (level_q == DEPTH_L);
  assign pop      = pop_req & ~empty;
  assign frame_ok = (len_q >= MIN_LEN_L) && (ver_q == 4'd2) && !err_q;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = commit & frame_ok & (~full | pop);
  assign drop     = commit & ~push;
  assign irq_o    = ~empty;
  assign head     = mem[rd_ptr_q];

  always_ff @(posedge c10_clk50m) begin
    if (push) mem[wr_ptr_q] <= {msg_q, seq_q, sec_q, ns_q};
  end

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + 5'd1;
      else if (pop && !push) level_q <= level_q - 5'd1;
      if (cnt_clr) begin
        rx_cnt_q   <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (push) rx_cnt_q   <= rx_cnt_q + 32'd1;
        if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (wbs_addr_i[4:2])
      3'd0: rd_data = {22'd0, full, empty, 3'd0, level_q};
      3'd1: if (!empty) rd_data = {head[95:80], 12'd0, head[99:96]};
      3'd2: if (!empty) rd_data = {16'd0, head[79:64]};
      3'd3: if (!empty) rd_data = head[63:32];
      3'd4: if (!empty) rd_data = head[31:0];
      3'd6: rd_data = rx_cnt_q;
      3'd7: rd_data = drop_cnt_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      wbs_ack_o  <= 1'b0;
      wbs_data_o <= '0;
    end else begin
      wbs_ack_o <= wb_fire;
      if (wb_fire) wbs_data_o <= rd_data;
    end
  end

endmodule
